button_anim: RTL and testbench

Parametrised, animated pressure-plate sprite for the VGA layer. Decides per pixel whether `DrawX/DrawY` falls on the button and produces a ROM address for the colour mapper. The button is a level press input from the character-collision logic. On each frame tick it sinks one pixel into the floor, reports a pressed state and event, and rises back when released. It sits between the collision logic and the colour mapper, feeding a `button_rom`-style sprite ROM of `W*H` entries.

---
 rtl/button_anim.sv | 124 ++++++++++++
 tb/tb_button_anim.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_anim.sv
// Animated pressure-plate sprite: pixel hit test, ROM address, and a
// frame-ticked sink/rise FSM driven by a level press input.
// Ports: Clk, Reset_n (async low), frame_clk (vsync level), DrawX/DrawY,
//   press, clear (latch release) -> is_button, button_address (registered),
//   pressed, press_evt, sink.
// Optional: define BUTTON_LATCH_EN so DOWN holds until clear on a tick.
module button_anim #(
  parameter int X0       = 172,
  parameter int Y0       = 241,
  parameter int W        = 20,
  parameter int H        = 10,
  parameter int SINK_MAX = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_clk,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          press,
  input  logic                          clear,
  output logic                          is_button,
  output logic [ADDR_W-1:0]             button_address,
  output logic                          pressed,
  output logic                          press_evt,
  output logic [$clog2(SINK_MAX+1)-1:0] sink
);

  localparam int SW = $clog2(SINK_MAX + 1);
  localparam int CW = 12 + ADDR_W;
  localparam logic [SW-1:0] SMAX = SW'(SINK_MAX);
  localparam logic [SW-1:0] ONE  = SW'(1);

  typedef enum logic [1:0] {
    UP,
    SINKING,
    DOWN,
    RISING
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sink_q, sink_d;
  logic            fclk_q;
  logic            evt_q, evt_d;
  logic            hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic tick;
  logic release_c;
  logic go_up;
  logic go_dn;

  assign tick = frame_clk & ~fclk_q;

`ifdef BUTTON_LATCH_EN
  assign release_c = clear;
`else
  assign release_c = ~press;
  logic unused_clear;
  assign unused_clear = clear;
`endif

  // Sink one step while pressed (any state but DOWN); rise one step
  // when released, except that UP has nowhere left to rise.
  assign go_up = tick & press & (state_q != DOWN);
  assign go_dn = tick & ((state_q == DOWN) ? release_c
                                           : (~press & (state_q != UP)));

  always_comb begin
    state_d = state_q;
    sink_d  = sink_q;
    unique case (1'b1)
      go_up: begin
        if (sink_q < SMAX) sink_d = sink_q + ONE;
        state_d = (sink_d == SMAX) ? DOWN : SINKING;
      end
      go_dn: begin
        if (sink_q != '0) sink_d = sink_q - ONE;
        state_d = (sink_d == '0) ? UP : RISING;
      end
      default: ;
    endcase
    evt_d = (state_d == DOWN) && (state_q != DOWN);
  end

  // Pixel path uses the registered sink; visible rows are the top H-sink
  // rows of the sprite shifted down by sink, bottom clipped at Y0+H.
  logic [CW-1:0] px, py, top;
  always_comb begin
    px    = CW'(DrawX);
    py    = CW'(DrawY);
    top   = CW'(Y0) + CW'(sink_q);
    hit_d = (px >= CW'(X0)) && (px < CW'(X0 + W)) &&
            (py >= top) && (py < CW'(Y0 + H));
    addr_d = '0;
    if (hit_d)
      addr_d = ADDR_W'((px - CW'(X0)) + (py - top) * CW'(W));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= UP;
      sink_q  <= '0;
      fclk_q  <= 1'b0;
      evt_q   <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sink_q  <= sink_d;
      fclk_q  <= frame_clk;
      evt_q   <= evt_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
    end
  end

  assign is_button      = hit_q;
  assign button_address = addr_q;
  assign pressed        = (state_q == DOWN);
  assign press_evt      = evt_q;
  assign sink           = sink_q;

endmodule

// File: tb/tb_button_anim.sv
// Self-checking bench for button_anim: directed steps plus random stimulus
// against an arithmetic depth/held model of the plate.
module tb_button_anim;

  localparam int X0 = 172;
  localparam int Y0 = 241;
  localparam int W  = 20;
  localparam int H  = 10;
  localparam int SM = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       press = 1'b0;
  logic       clear = 1'b0;
  logic       is_button;
  logic [7:0] button_address;
  logic       pressed;
  logic       press_evt;
  logic [2:0] sink;

  int tests = 0;
  int fails = 0;
  int evt_cnt = 0;

  // Model: depth in pixels, whether the plate is held down, vsync history.
  int depth_m = 0;
  bit held_m = 0;
  bit fq_m = 0;
  bit evt_m = 0;
  bit hit_m = 0;
  int addr_m = 0;

  button_anim dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .press(press), .clear(clear),
    .is_button(is_button), .button_address(button_address),
    .pressed(pressed), .press_evt(press_evt), .sink(sink)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    depth_m = 0;
    held_m  = 0;
    fq_m    = 0;
    evt_m   = 0;
    hit_m   = 0;
    addr_m  = 0;
  endtask

  task automatic model_edge();
    int x, y;
    bit tk, rel;
    x = int'(DrawX);
    y = int'(DrawY);
    hit_m = (x >= X0) && (x < X0 + W) &&
            (y >= Y0 + depth_m) && (y < Y0 + H);
    addr_m = hit_m ? (((x - X0) + (y - Y0 - depth_m) * W) % 256) : 0;
    tk = frame_clk && !fq_m;
    fq_m = frame_clk;
    evt_m = 0;
    if (tk) begin
`ifdef BUTTON_LATCH_EN
      rel = clear;
`else
      rel = !press;
`endif
      if (held_m) begin
        if (rel) begin
          depth_m = depth_m - 1;
          held_m = 0;
        end
      end else if (press) begin
        if (depth_m < SM) depth_m = depth_m + 1;
        if (depth_m == SM) begin
          held_m = 1;
          evt_m = 1;
        end
      end else if (depth_m > 0) begin
        depth_m = depth_m - 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1;
    if (press_evt === 1'b1) evt_cnt++;
    chk("is_button", is_button, hit_m);
    chk("address", button_address, addr_m);
    chk("sink", sink, depth_m);
    chk("pressed", pressed, held_m);
    chk("press_evt", press_evt, evt_m);
  endtask

  task automatic tick_cyc();
    frame_clk = 1'b1;
    cyc();
    frame_clk = 1'b0;
    cyc();
  endtask

  initial begin
    int e0;
    model_reset();
    #12;
    chk("rst_is_button", is_button, 0);
    chk("rst_address", button_address, 0);
    chk("rst_sink", sink, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_evt", press_evt, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc();

    // Hit test while idle
    DrawX = 10'd172; DrawY = 10'd241; cyc();
    chk("hit_origin", is_button, 1);
    chk("addr_origin", button_address, 0);
    DrawX = 10'd191; DrawY = 10'd250; cyc();
    chk("addr_corner", button_address, 199);
    DrawX = 10'd192; cyc();
    chk("miss_right", is_button, 0);
    chk("miss_addr", button_address, 0);

    // Sink to DOWN
    press = 1'b1;
    e0 = evt_cnt;
    for (int k = 1; k <= SM; k++) begin
      tick_cyc();
      chk("sink_seq", sink, k);
    end
    chk("down_pressed", pressed, 1);
    chk("down_evt_once", evt_cnt - e0, 1);
    tick_cyc();
    chk("no_refire", evt_cnt - e0, 1);
    DrawX = 10'd172; DrawY = 10'd244; cyc();
    chk("clip_row", is_button, 0);
    DrawY = 10'd245; cyc();
    chk("shift_hit", is_button, 1);
    chk("shift_addr", button_address, 0);

`ifdef BUTTON_LATCH_EN
    press = 1'b0;
    for (int k = 0; k < 10; k++) tick_cyc();
    chk("latch_hold", pressed, 1);
    clear = 1'b1; tick_cyc(); clear = 1'b0;
    chk("latch_clear_sink", sink, 3);
    chk("latch_clear_pressed", pressed, 0);
`endif

    // Back to UP, then reversal mid-sink
    press = 1'b0;
    for (int k = 0; k < 6; k++) tick_cyc();
    chk("back_up", sink, 0);
    e0 = evt_cnt;
    press = 1'b1;
    tick_cyc(); tick_cyc();
    chk("rev_sink2", sink, 2);
    press = 1'b0;
    tick_cyc();
    chk("rev_sink1", sink, 1);
    tick_cyc();
    chk("rev_sink0", sink, 0);
    chk("rev_no_evt", evt_cnt - e0, 0);

    // Frame tick detection: long high level gives one tick
    press = 1'b1;
    frame_clk = 1'b1;
    for (int k = 0; k < 1000; k++) cyc();
    frame_clk = 1'b0;
    cyc();
    chk("one_tick", sink, 1);

    // Reset mid-animation
    tick_cyc();
    DrawX = 10'd180; DrawY = 10'd248; cyc();
    chk("pre_rst_sink", sink, 2);
    chk("pre_rst_hit", is_button, 1);
    Reset_n = 1'b0;
    #1;
    chk("async_sink", sink, 0);
    chk("async_pressed", pressed, 0);
    chk("async_hit", is_button, 0);
    model_reset();
    press = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc();

    // Random stimulus
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 7) == 0) press = ~press;
      clear = ($urandom_range(0, 9) == 0);
      DrawX = 10'($urandom_range(165, 200));
      DrawY = 10'($urandom_range(235, 256));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
